// File: rtl/mdr_rem_seq.sv
// Partial-remainder/product register and step sequencer for the radix-2 multi-cycle
// MULT/DIV/ROOT unit. Define MDR_REM_SIGNED_EN for signed (truncating) DIV.
module mdr_rem_seq #(
    parameter int DW = 8,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [DW-1:0]   load_val,
    input  logic [DW-1:0]   alu_res,
    input  logic            alu_flag,
`ifdef MDR_REM_SIGNED_EN
    input  logic            dvs_neg,
`endif
    output logic [DW:0]     alu_opa,
    output logic [2*DW-1:0] rem_val,
    output logic [1:0]      rem_2lsb,
    output logic            rem_msb,
    output logic [DW/2-1:0] root_q,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [CW-1:0]   step_cnt
);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_ROOT = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam logic [CW-1:0] N_FULL = CW'(DW);
    localparam logic [CW-1:0] N_HALF = CW'(DW / 2);

    generate
        if (DW < 4 || (DW % 2) != 0) begin : g_bad_dw
            $error("mdr_rem_seq: DW must be even and >= 4");
        end
    endgenerate

`ifdef MDR_REM_SIGNED_EN
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t          state, state_nxt;
    logic [2*DW-1:0] rem, rem_nxt;
    logic [DW/2-1:0] root_r, root_nxt;
    logic [CW-1:0]   cnt_r, cnt_nxt;
    logic [1:0]      op_r, op_nxt;
    logic            done_r, done_nxt;
    logic            err_r, err_nxt;

    logic [DW:0]     mult_sel;
    logic [2*DW-1:0] rem_step;
    logic [DW/2-1:0] root_step;
    logic [CW-1:0]   n_steps;
    logic            last_step;
    logic [DW-1:0]   load_mag;

`ifdef MDR_REM_SIGNED_EN
    logic          sgn_r, sgn_nxt;
    logic          dneg_r, dneg_nxt;
    logic          load_neg;
    logic [DW-1:0] fix_q, fix_r;

    // Only DIV operands are two's complement; MULT/ROOT load raw bits.
    assign load_neg = (op == OP_DIV) && load_val[DW-1];
    assign load_mag = load_neg ? -load_val : load_val;
    assign fix_q    = (sgn_r ^ dneg_r) ? -rem[DW-1:0] : rem[DW-1:0];
    assign fix_r    = sgn_r ? -rem[2*DW-1:DW] : rem[2*DW-1:DW];
`else
    assign load_mag = load_val;
`endif

    // ALU A operand is the only combinational output.
    always_comb begin
        case (op_r)
            OP_DIV:  alu_opa = rem[2*DW-1:DW-1];
            OP_ROOT: alu_opa = rem[2*DW-2:DW-2];
            default: alu_opa = {1'b0, rem[2*DW-1:DW]};
        endcase
    end

    // One radix-2 step: commit the ALU result or restore the shifted register.
    always_comb begin
        mult_sel  = rem[0] ? {alu_flag, alu_res} : {1'b0, rem[2*DW-1:DW]};
        rem_step  = rem;
        root_step = root_r;
        case (op_r)
            OP_DIV: begin
                if (alu_flag)
                    rem_step = {rem[2*DW-2:DW-1], rem[DW-2:0], 1'b0};
                else
                    rem_step = {alu_res, rem[DW-2:0], 1'b1};
            end
            OP_ROOT: begin
                rem_step  = {(alu_flag ? rem[2*DW-3:DW-2] : alu_res), rem[DW-3:0], 2'b00};
                root_step = {root_r[DW/2-2:0], ~alu_flag};
            end
            default: rem_step = {mult_sel, rem[DW-1:1]};
        endcase
    end

    assign n_steps   = (op_r == OP_ROOT) ? N_HALF : N_FULL;
    assign last_step = (cnt_r == n_steps - CW'(1));

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        root_nxt  = root_r;
        cnt_nxt   = cnt_r;
        op_nxt    = op_r;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
`ifdef MDR_REM_SIGNED_EN
        sgn_nxt   = sgn_r;
        dneg_nxt  = dneg_r;
`endif
        if (clr) begin
            state_nxt = IDLE;
            rem_nxt   = '0;
            root_nxt  = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_RSV) begin
                            err_nxt = 1'b1;
                        end else begin
                            state_nxt = RUN;
                            rem_nxt   = {{DW{1'b0}}, load_mag};
                            root_nxt  = '0;
                            cnt_nxt   = '0;
                            op_nxt    = op;
`ifdef MDR_REM_SIGNED_EN
                            sgn_nxt   = load_neg;
                            dneg_nxt  = dvs_neg;
`endif
                        end
                    end
                end
                RUN: begin
                    rem_nxt  = rem_step;
                    root_nxt = root_step;
                    cnt_nxt  = cnt_r + CW'(1);
                    if (last_step) begin
`ifdef MDR_REM_SIGNED_EN
                        if (op_r == OP_DIV) begin
                            state_nxt = FIX;
                        end else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
`else
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
`endif
                    end
                end
`ifdef MDR_REM_SIGNED_EN
                FIX: begin
                    rem_nxt   = {fix_r, fix_q};
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem    <= '0;
            root_r <= '0;
            cnt_r  <= '0;
            op_r   <= OP_MULT;
            done_r <= 1'b0;
            err_r  <= 1'b0;
`ifdef MDR_REM_SIGNED_EN
            sgn_r  <= 1'b0;
            dneg_r <= 1'b0;
`endif
        end else begin
            rem    <= rem_nxt;
            root_r <= root_nxt;
            cnt_r  <= cnt_nxt;
            op_r   <= op_nxt;
            done_r <= done_nxt;
            err_r  <= err_nxt;
`ifdef MDR_REM_SIGNED_EN
            sgn_r  <= sgn_nxt;
            dneg_r <= dneg_nxt;
`endif
        end
    end

    assign rem_val  = rem;
    assign rem_2lsb = rem[1:0];
    assign rem_msb  = rem[2*DW-1];
    assign root_q   = root_r;
    assign busy     = (state != IDLE);
    assign done     = done_r;
    assign err      = err_r;
    assign step_cnt = cnt_r;

endmodule

// File: tb/tb_mdr_rem_seq.sv
// Bench for mdr_rem_seq: emulates the external ALU and checks every cycle against
// an arithmetic model (product, quotient/remainder, integer square root).
module tb_mdr_rem_seq;
    localparam int DW = 8;
    localparam int CW = $clog2(DW + 1);
`ifdef MDR_REM_SIGNED_EN
    localparam bit SDIV = 1'b1;
`else
    localparam bit SDIV = 1'b0;
`endif

    logic            clk = 1'b0, rst = 1'b0, clr = 1'b0, start = 1'b0, dvs_neg = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [DW-1:0]   load_val = '0;
    logic [DW-1:0]   alu_res;
    logic            alu_flag;
    logic [DW:0]     alu_opa;
    logic [2*DW-1:0] rem_val;
    logic [1:0]      rem_2lsb;
    logic            rem_msb;
    logic [DW/2-1:0] root_q;
    logic            busy, done, err;
    logic [CW-1:0]   step_cnt;

    int n_chk = 0, n_fail = 0;

    mdr_rem_seq #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .op(op), .load_val(load_val),
        .alu_res(alu_res), .alu_flag(alu_flag),
`ifdef MDR_REM_SIGNED_EN
        .dvs_neg(dvs_neg),
`endif
        .alu_opa(alu_opa), .rem_val(rem_val), .rem_2lsb(rem_2lsb), .rem_msb(rem_msb),
        .root_q(root_q), .busy(busy), .done(done), .err(err), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    // External ALU: add (MULT), subtract divisor (DIV), subtract {root_q,01} (ROOT)
    logic [1:0]    alu_mode = 2'b00;
    logic [DW-1:0] alu_b = '0;
    logic [DW+1:0] alu_t;
    always_comb begin
        alu_t = '0;
        case (alu_mode)
            2'b00:   alu_t = {1'b0, {1'b0, alu_opa[DW-1:0]} + {1'b0, alu_b}};
            2'b01:   alu_t = {1'b0, alu_opa} - {2'b00, alu_b};
            default: alu_t = {1'b0, alu_opa} - (DW+2)'({root_q, 2'b01});
        endcase
        alu_res  = alu_t[DW-1:0];
        alu_flag = (alu_mode == 2'b00) ? alu_t[DW] : alu_t[DW+1];
    end

    function automatic logic [2*DW-1:0] ref_rem(input logic [1:0] o, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b, input logic dn);
        logic [DW-1:0] q, r, m;
        logic          neg;
        int            s;
        case (o)
            2'b00: return {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
            2'b01: begin
                neg = SDIV && a[DW-1];
                m   = neg ? -a : a;
                if (b == '0) begin q = '1; r = m; end
                else begin q = m / b; r = m % b; end
                if (neg ^ (SDIV && dn)) q = -q;
                if (neg) r = -r;
                return {r, q};
            end
            default: begin
                s = 0;
                while ((s + 1) * (s + 1) <= int'(a)) s++;
                return {DW'(int'(a) - s * s), {DW{1'b0}}};
            end
        endcase
    endfunction

    function automatic logic [DW/2-1:0] ref_root(input logic [1:0] o, input logic [DW-1:0] a);
        int s;
        s = 0;
        if (o == 2'b10) while ((s + 1) * (s + 1) <= int'(a)) s++;
        return (DW/2)'(s);
    endfunction

    // Cycle-level model: cycles remaining, steps done, and the final answer
    int              m_left = 0, m_cnt = 0, m_n = 0;
    logic [2*DW-1:0] m_rem = '0, m_fin = '0;
    logic [DW/2-1:0] m_root = '0, m_fin_root = '0;
    logic            m_done = 1'b0, m_err = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left <= 0; m_cnt <= 0; m_n <= 0;
            m_rem <= '0; m_root <= '0; m_done <= 1'b0; m_err <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (clr) begin
                m_left <= 0; m_cnt <= 0; m_rem <= '0; m_root <= '0;
            end else if (m_left == 0) begin
                if (start && op == 2'b11) begin
                    m_err <= 1'b1;
                end else if (start) begin
                    m_n        <= (op == 2'b10) ? DW / 2 : DW;
                    m_left     <= ((op == 2'b10) ? DW / 2 : DW) + ((SDIV && op == 2'b01) ? 1 : 0);
                    m_cnt      <= 0;
                    m_rem      <= {{DW{1'b0}}, (SDIV && op == 2'b01 && load_val[DW-1]) ? -load_val : load_val};
                    m_root     <= '0;
                    m_fin      <= ref_rem(op, load_val, alu_b, dvs_neg);
                    m_fin_root <= ref_root(op, load_val);
                end
            end else begin
                m_left <= m_left - 1;
                if (m_cnt < m_n) m_cnt <= m_cnt + 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_rem  <= m_fin;
                    m_root <= m_fin_root;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_left != 0));
        chk("done", 64'(done), 64'(m_done));
        chk("err", 64'(err), 64'(m_err));
        chk("step_cnt", 64'(step_cnt), 64'(m_cnt));
        if (m_left == 0 || m_cnt == 0) begin
            chk("rem_val", 64'(rem_val), 64'(m_rem));
            chk("root_q", 64'(root_q), 64'(m_root));
            chk("rem_2lsb", 64'(rem_2lsb), 64'(m_rem[1:0]));
            chk("rem_msb", 64'(rem_msb), 64'(m_rem[2*DW-1]));
        end
    end

    task automatic do_start(input logic [1:0] o, input logic [DW-1:0] lv,
                            input logic [DW-1:0] b, input logic dn);
        @(posedge clk); #1;
        if (o != 2'b11 && m_left == 0 && !clr) begin
            alu_mode = o;
            alu_b    = b;
        end
        start = 1'b1; op = o; load_val = lv; dvs_neg = dn;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) return;
            @(posedge clk);
            cyc++;
        end
        n_chk++; n_fail++;
        $display("FAIL done_timeout: no done pulse within 40 cycles");
        cyc = -1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && m_left != 0; k++) begin
            @(posedge clk); #1;
        end
        if (m_left != 0) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: model still busy after 60 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [1:0] ro;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rem", 64'(rem_val), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        rst = 1'b1;

        // MULT 11 * 13
        do_start(2'b00, 8'd11, 8'd13, 1'b0);
        wait_done(cyc);
        chk("mult_latency", 64'(cyc), 64'd9);
        chk("mult_rem", 64'(rem_val), 64'h008F);
        chk("mult_steps", 64'(step_cnt), 64'd8);

        // DIV 200 / 7 and divide by zero
        do_start(2'b01, 8'd200, 8'd7, 1'b0);
        wait_done(cyc);
        chk("div_rem", 64'(rem_val), 64'h041C);
        do_start(2'b01, 8'd200, 8'd0, 1'b0);
        wait_done(cyc);
        chk("div0_rem", 64'(rem_val), 64'hC8FF);

        // ROOT 200
        do_start(2'b10, 8'd200, 8'd0, 1'b0);
        wait_done(cyc);
        chk("root_latency", 64'(cyc), 64'd5);
        chk("root_q", 64'(root_q), 64'd14);
        chk("root_rem", 64'(rem_val[15:8]), 64'd4);

        // start while busy is ignored
        do_start(2'b00, 8'd11, 8'd13, 1'b0);
        do_start(2'b01, 8'd5, 8'd3, 1'b0);
        wait_done(cyc);
        chk("ign_start_rem", 64'(rem_val), 64'h008F);

        // clr at step 3
        do_start(2'b00, 8'd200, 8'd77, 1'b0);
        for (int k = 0; k < 20 && m_cnt != 3; k++) begin
            @(posedge clk); #1;
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_busy", 64'(busy), 64'h0);
        chk("clr_rem", 64'(rem_val), 64'h0);
        chk("clr_cnt", 64'(step_cnt), 64'h0);
        repeat (3) @(negedge clk);
        chk("clr_nodone", 64'(done), 64'h0);

        // reserved op
        do_start(2'b11, 8'h5A, 8'd1, 1'b0);
        chk("rsv_err", 64'(err), 64'h1);
        chk("rsv_busy", 64'(busy), 64'h0);
        @(posedge clk); #1;
        chk("rsv_err_pulse", 64'(err), 64'h0);

        // clr beats start
        clr = 1'b1; start = 1'b1; op = 2'b00; load_val = 8'd55;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        chk("clr_start_busy", 64'(busy), 64'h0);

        // async reset mid-run
        do_start(2'b00, 8'hAB, 8'hCD, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_rem", 64'(rem_val), 64'h0);
        chk("arst_cnt", 64'(step_cnt), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

`ifdef MDR_REM_SIGNED_EN
        do_start(2'b01, 8'h9C, 8'd7, 1'b0);
        wait_done(cyc);
        chk("sdiv_latency", 64'(cyc), 64'd10);
        chk("sdiv_rem", 64'(rem_val), 64'hFEF2);
`endif

        // randomized operations with occasional reserved ops, stray starts and flushes
        for (int i = 0; i < 60; i++) begin
            ro = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_start(ro, 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom),
                     1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_start(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1 clr = 1'b1;
                @(posedge clk); #1;
                clr = 1'b0;
            end
            wait_idle();
            @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdr_rem_seq.md
Name: mdr_rem_seq

Overview:
- Parametrised partial-remainder register and step sequencer for the radix-2 multi-cycle MULT/DIV/ROOT unit.
- Owns the 2*DW-bit remainder/product register, the ROOT result register, the step counter and the start/busy/done handshake.
- The external ALU performs the trial add/subtract each cycle. This block drives the ALU's A operand and commits or restores the result.
- Supersedes the fixed-width remainder register: explicit sequencing, error reporting and a synchronous flush.

Parameters:
- DW, 8, operand width; must be even and >= 4.
- CW, $clog2(DW+1), step counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush to IDLE.
- start  in  1  start pulse, sampled in IDLE only.
- op  in  2  00 MULT, 01 DIV, 10 ROOT, 11 reserved.
- load_val  in  DW  multiplier, dividend or radicand.
- alu_res  in  DW  ALU result for the current step.
- alu_flag  in  1  carry-out (MULT); borrow, i.e. trial result negative (DIV/ROOT).
- alu_opa  out  DW+1  ALU A operand, combinational from the register.
- rem_val  out  2*DW  register contents.
- rem_2lsb  out  2  rem_val[1:0].
- rem_msb  out  1  rem_val[2*DW-1].
- root_q  out  DW/2  square-root result register.
- busy  out  1  high in RUN (and FIX).
- done  out  1  one-cycle pulse when the result is valid.
- err  out  1  one-cycle pulse on start with op=11.
- step_cnt  out  CW  steps completed.

Behaviour:
- Reset: every register and output is 0, state IDLE.
- States: IDLE, RUN, FIX (FIX exists only with the macro).
- clr has highest priority after reset: next edge clears rem, root_q and step_cnt, returns to IDLE, no done pulse. clr beats a simultaneous start.
- IDLE, start and op != 11:
  - Load rem = {DW'0, load_val}, root_q = 0, step_cnt = 0.
  - Latch op internally; op is ignored until the next start.
  - Go to RUN.
- IDLE, start and op == 11: err pulses next cycle; state and registers are unchanged.
- start while busy is ignored.
- Step count N: DW for MULT and DIV, DW/2 for ROOT. One step per RUN cycle, step_cnt increments each step.
- After step N: go to IDLE (or FIX) and pulse done for exactly 1 cycle. rem and root_q hold until the next start or clr.
- MULT (shift-add, unsigned):
  - alu_opa = {1'b0, rem[2DW-1:DW]}.
  - sel = rem[0] ? {alu_flag, alu_res} : {1'b0, rem[2DW-1:DW]}.
  - rem <= {sel, rem[DW-1:1]}. Product is in rem.
- DIV (restoring, unsigned):
  - alu_opa = rem[2DW-1:DW-1].
  - !alu_flag: rem <= {alu_res, rem[DW-2:0], 1'b1}.
  - alu_flag: rem <= {rem[2DW-2:DW-1], rem[DW-2:0], 1'b0}.
  - Quotient ends in the low half, remainder in the high half.
- ROOT (restoring, 2 bits per step):
  - alu_opa = rem[2DW-2:DW-2]. The ALU subtracts {root_q, 2'b01}.
  - !alu_flag: upper <= alu_res, root_q <= {root_q[DW/2-2:0], 1}.
  - alu_flag: upper <= rem[2DW-3:DW-2], root_q shifts in 0.
  - Lower half <= {rem[DW-3:0], 2'b00} in both cases.
  - Remainder ends in the high half.
- Zero divisor: no special case; result is quotient all-ones and remainder = dividend.
- Latency: start edge, then N RUN edges; done is high in the cycle after the last step (start + N + 1).
- Outputs are registered except alu_opa.

Optional Feature:
- Macro: MDR_REM_SIGNED_EN.
- With the macro:
  - Adds input dvs_neg (divisor sign).
  - DIV treats load_val as two's complement: loads its magnitude and records its sign.
  - After RUN, one FIX cycle negates the quotient if sign ^ dvs_neg, and negates the remainder if sign set (truncating division).
  - done moves one cycle later.
  - MULT and ROOT are unaffected.
- Without the macro: unsigned only, no FIX state, no dvs_neg port.

Test Plan:
- DW=8, MULT, load 11, bench ALU adds 13 -> done 9 cycles after start, rem_val=0x008F, step_cnt=8.
- DIV, load 200, divisor 7 -> rem_val=0x041C (rem 4, quotient 28). Divisor 0 -> rem_val=0xC8FF.
- ROOT, load 200 -> done after 4 steps, root_q=14, rem_val[15:8]=4.
- start during RUN ignored. clr at step 3 -> IDLE next cycle, rem_val=0, no done. start with op=11 -> err pulse, state IDLE. clr+start same cycle -> stays IDLE.
- Async rst asserted mid-RUN -> all outputs 0 immediately, IDLE after release.
- MDR_REM_SIGNED_EN: DIV load -100 (0x9C), divisor 7, dvs_neg=0 -> done at start+10, rem_val=0xFEF2.
